// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared opcode constants, instruction class encodings and opcode pre-decode
//
// Purpose : one home for the opcode values and 3-bit class tags. The fetch/decode
//           queue, decode, sign-extend and control logic all use these values.
// Contents: OPC_* opcode constants, instr_class_e class encoding, predecode_class().

package if_id_buffer_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ITYPE   = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_UNKNOWN = 3'd7
    } instr_class_e;

    // Opcode -> class tag, so decode and hazard logic never re-decode the opcode.
    function automatic instr_class_e predecode_class(input logic [6:0] opcode);
        instr_class_e cls;
        case (opcode)
            OPC_RTYPE: cls = CLS_RTYPE;
            OPC_ITYPE: cls = CLS_ITYPE;
            OPC_LW:    cls = CLS_LW;
            OPC_SW:    cls = CLS_SW;
            OPC_BEQ:   cls = CLS_BEQ;
            default:   cls = CLS_UNKNOWN;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - instruction queue between fetch and decode with pre-decoded class tag
//
// Purpose : DEPTH-entry FIFO of {instr, pc, class}. It absorbs decode stalls so that
//           fetch can keep issuing. Flush discards every queued entry.
// Ports   : clk_i, rst_i (async, active-low), flush_i
//           in_valid_i / in_ready_o / in_instr_i / in_pc_i          - push side (fetch)
//           out_valid_o / out_ready_i / out_instr_o / out_pc_o /
//           out_class_o                                             - pop side (decode)
//           count_o                                                 - occupied entries

module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [XLEN-1:0]            in_instr_i,
    input  logic [XLEN-1:0]            in_pc_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_instr_o,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [2:0]                 out_class_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Payload storage. It has no reset, because count_q alone decides which slots are live.
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [2:0]      class_mem [DEPTH];

    logic push;
    logic pop;
    logic [2:0] push_class;

    // Ready and valid come from registered count only. A full queue therefore refuses
    // a push even if decode pops in the same cycle; the freed slot is usable next cycle.
    assign in_ready_o  = (count_q != CNT_FULL);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign push_class  = predecode_class(in_instr_i[6:0]);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            // Redirect wins over everything, and any concurrent push/pop is dropped.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by natural overflow.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            instr_mem[wr_ptr_q] <= in_instr_i;
            pc_mem[wr_ptr_q]    <= in_pc_i;
            class_mem[wr_ptr_q] <= push_class;
        end
    end

    // The head is read from storage only, so nothing bypasses from input to output.
    // An empty queue presents zeros and the unknown class, and never shows stale payload.
    assign out_instr_o = out_valid_o ? instr_mem[rd_ptr_q] : '0;
    assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr_q]    : '0;
    assign out_class_o = out_valid_o ? class_mem[rd_ptr_q] : CLS_UNKNOWN;
    assign count_o     = count_q;

    no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_i)
                                    !(push && (count_q == CNT_FULL)));
    no_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_i)
                                     !(pop && (count_q == '0)));

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - scoreboard bench for if_id_buffer with directed vectors

module tb_if_id_buffer;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [XLEN-1:0]   in_instr_i = '0;
    logic [XLEN-1:0]   in_pc_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [XLEN-1:0]   out_instr_o;
    logic [XLEN-1:0]   out_pc_o;
    logic [2:0]        out_class_o;
    logic [$clog2(DEPTH):0] count_o;

    if_id_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_instr_i  (in_instr_i),
        .in_pc_i     (in_pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_instr_o (out_instr_o),
        .out_pc_o    (out_pc_o),
        .out_class_o (out_class_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  cls;
    } ent_t;

    ent_t        sb_q[$];
    int          m_count = 0;
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  drv_cls = 3'd7;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor samples on the falling edge, between the stimulus update (posedge+1) and the commit edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            sb_q.delete();
            m_count = 0;
        end else begin
            logic pop_m, push_m;
            ent_t e;
            chk("count", 32'(count_o), 32'(m_count));
            chk("in_ready", 32'(in_ready_o), 32'(m_count != DEPTH));
            chk("out_valid", 32'(out_valid_o), 32'(m_count != 0));
            if (m_count != 0) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underrun", 32'(0), 32'(1));
                end else begin
                    chk("head_instr", out_instr_o, sb_q[0].instr);
                    chk("head_pc", out_pc_o, sb_q[0].pc);
                    chk("head_class", 32'(out_class_o), 32'(sb_q[0].cls));
                end
            end else begin
                chk("empty_instr", out_instr_o, 32'h0);
                chk("empty_class", 32'(out_class_o), 32'd7);
            end
            pop_m  = out_ready_i && (m_count != 0);
            push_m = in_valid_i && (m_count != DEPTH);
            if (flush_i) begin
                sb_q.delete();
                m_count = 0;
            end else begin
                if (pop_m && sb_q.size() != 0) void'(sb_q.pop_front());
                if (push_m) begin
                    e.instr = in_instr_i;
                    e.pc    = in_pc_i;
                    e.cls   = drv_cls;
                    sb_q.push_back(e);
                end
                m_count = m_count + int'(push_m) - int'(pop_m);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [2:0] cls, input logic rdy, input logic fl);
        in_valid_i  = v;
        in_instr_i  = ins;
        in_pc_i     = pc;
        drv_cls     = cls;
        out_ready_i = rdy;
        flush_i     = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 3'd7, rdy, 1'b0);
    endtask

    logic [31:0] cls_instr [5] = '{32'h002081b3, 32'h00208463, 32'h0000a103, 32'h0020a023, 32'hffffffff};
    logic [2:0]  cls_exp   [5] = '{3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    initial begin
        // Power-on reset
        rst_i = 1'b0;
        #12;
        chk("por_valid", 32'(out_valid_o), 32'd0);
        chk("por_ready", 32'(in_ready_o), 32'd1);
        chk("por_count", 32'(count_o), 32'd0);
        chk("por_class", 32'(out_class_o), 32'd7);
        chk("por_pc", out_pc_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        idle(1'b0, 1);

        // Fill with decode stalled; the third push is held and refused
        drive(1'b1, 32'h00500093, 32'h0, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h00a00113, 32'h4, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h00f00193, 32'h8, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h00f00193, 32'h8, 3'd1, 1'b0, 1'b0);

        // Asynchronous reset with two entries queued
        in_valid_i = 1'b0;
        rst_i = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_instr", out_instr_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        idle(1'b0, 1);

        // Streaming: a push every cycle with decode always ready
        for (int i = 0; i < 8; i++)
            drive(1'b1, 32'h00000013 | (32'(i) << 20), 32'(i * 4), 3'd1, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Full queue plus pop: push refused that cycle, accepted the next
        drive(1'b1, 32'h00100093, 32'h100, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h00200093, 32'h104, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h00300093, 32'h108, 3'd1, 1'b1, 1'b0);
        drive(1'b1, 32'h00300093, 32'h108, 3'd1, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Flush with concurrent push and pop
        drive(1'b1, 32'h00400093, 32'h200, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h00500093, 32'h204, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h00600093, 32'h208, 3'd1, 1'b1, 1'b1);
        idle(1'b0, 2);

        // Class pre-decode; empty queue with out_ready high ignores the pop
        for (int i = 0; i < 5; i++)
            drive(1'b1, cls_instr[i], 32'h300 + 32'(i * 4), cls_exp[i], 1'b1, 1'b0);
        idle(1'b1, 3);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
